// File: rtl/sequenciador_sensores_if.sv
// ---------------------------------------------------------------------------
// sequenciador_sensores_if
// Handshake between the sensor sequencer and the shared ultrasonic
// interface block.
//   medir_if   : one-cycle measurement request (sequencer -> interface)
//   reset_if   : one-cycle active-high reset   (sequencer -> interface)
//   pronto_if  : one-cycle done pulse          (interface -> sequencer)
//   medida_if  : 12-bit distance, valid while pronto_if=1
// Modports: master = sequencer side, slave = interface block side.
// ---------------------------------------------------------------------------
interface sequenciador_sensores_if;
  logic        medir_if;
  logic        reset_if;
  logic        pronto_if;
  logic [11:0] medida_if;

  modport master (
    output medir_if,
    output reset_if,
    input  pronto_if,
    input  medida_if
  );

  modport slave (
    input  medir_if,
    input  reset_if,
    output pronto_if,
    output medida_if
  );
endinterface

// File: rtl/sequenciador_sensores.sv
// ---------------------------------------------------------------------------
// sequenciador_sensores
// Time-shares one ultrasonic interface block between N_SENSORES sensors.
// Each sensor gets a request, a watchdog-supervised wait, and either a
// stored distance or a failure flag; a round ends with a one-cycle
// ciclo_pronto pulse followed by an idle interval.
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous active-low reset
//   ligar        : level, 1 = run rounds continuously
//   bus          : handshake to the interface block (master side)
//   sel_sensor   : index of the active sensor (echo/trigger mux select)
//   medidas      : last good distance per sensor, sensor k at [12k+11:12k]
//   falha        : bit k = last attempt on sensor k timed out
//   ciclo_pronto : one-cycle pulse when a round completes
//   db_estado    : current state code
// ---------------------------------------------------------------------------
module sequenciador_sensores #(
  parameter int N_SENSORES = 4,
  parameter int WATCHDOG   = 1500000,
  parameter int INTERVALO  = 3000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ligar,
  sequenciador_sensores_if.master   bus,
  output logic [1:0]                sel_sensor,
  output logic [12*N_SENSORES-1:0]  medidas,
  output logic [N_SENSORES-1:0]     falha,
  output logic                      ciclo_pronto,
  output logic [3:0]                db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    DISPARA  = 4'd2,
    AGUARDA  = 4'd3,
    ARMAZENA = 4'd4,
    FALHA    = 4'd5,
    PROXIMO  = 4'd6,
    ESPERA   = 4'd7
  } estado_t;

  localparam int WD_W = (WATCHDOG  > 1) ? $clog2(WATCHDOG)  : 1;
  localparam int IV_W = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG - 1);
  localparam logic [IV_W-1:0] IV_MAX = IV_W'(INTERVALO - 1);
  localparam logic [1:0]      ULTIMO = 2'(N_SENSORES - 1);

  estado_t         estado;
  estado_t         proximo;
  logic [WD_W-1:0] cnt_wd;
  logic [IV_W-1:0] cnt_iv;
  logic [11:0]     captura;
  logic            medir_d;
  logic            reset_d;
  logic            ciclo_d;

  assign db_estado = estado;

  // Next-state logic and decode of the next-cycle output values
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL: begin
        if (ligar) proximo = PREPARA;
        else       proximo = INICIAL;
      end
      PREPARA: proximo = DISPARA;
      DISPARA: proximo = AGUARDA;
      AGUARDA: begin
        // pronto has priority over a simultaneous timeout
        if (bus.pronto_if)         proximo = ARMAZENA;
        else if (cnt_wd == WD_MAX) proximo = FALHA;
        else                       proximo = AGUARDA;
      end
      ARMAZENA: proximo = PROXIMO;
      FALHA:    proximo = PROXIMO;
      PROXIMO: begin
        if (sel_sensor < ULTIMO) proximo = PREPARA;
        else if (ligar)          proximo = ESPERA;
        else                     proximo = INICIAL;
      end
      ESPERA: begin
        if (!ligar)                proximo = INICIAL;
        else if (cnt_iv == IV_MAX) proximo = PREPARA;
        else                       proximo = ESPERA;
      end
      default: proximo = INICIAL;
    endcase

    // Outputs are registered from the next state so they line up with it
    medir_d = (proximo == DISPARA);
    reset_d = (proximo == FALHA);
    // sel_sensor does not change when entering PROXIMO, so it already
    // identifies whether this is the last sensor of the round
    ciclo_d = (proximo == PROXIMO) && (sel_sensor == ULTIMO);
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Counters, sensor select, capture and per-sensor result storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_wd     <= '0;
      cnt_iv     <= '0;
      captura    <= 12'h000;
      sel_sensor <= 2'd0;
      medidas    <= '0;
      falha      <= '0;
    end else begin
      case (estado)
        INICIAL: sel_sensor <= 2'd0;
        PREPARA: cnt_wd <= '0;
        AGUARDA: begin
          if (bus.pronto_if) captura <= bus.medida_if;
          // hold at the limit instead of wrapping; cleared again in PREPARA
          if (proximo == AGUARDA) cnt_wd <= cnt_wd + WD_W'(1);
        end
        ARMAZENA: begin
          for (int k = 0; k < N_SENSORES; k++) begin
            if (sel_sensor == 2'(k)) begin
              medidas[12*k +: 12] <= captura;
              falha[k]            <= 1'b0;
            end
          end
        end
        FALHA: begin
          for (int k = 0; k < N_SENSORES; k++) begin
            if (sel_sensor == 2'(k)) falha[k] <= 1'b1;
          end
        end
        PROXIMO: begin
          cnt_iv <= '0;
          if (sel_sensor < ULTIMO) sel_sensor <= sel_sensor + 2'd1;
          else                     sel_sensor <= 2'd0;
        end
        ESPERA: begin
          if (proximo == ESPERA) cnt_iv <= cnt_iv + IV_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and round-complete outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.medir_if <= 1'b0;
      bus.reset_if <= 1'b0;
      ciclo_pronto <= 1'b0;
    end else begin
      bus.medir_if <= medir_d;
      bus.reset_if <= reset_d;
      ciclo_pronto <= ciclo_d;
    end
  end

endmodule

// File: tb/tb_sequenciador_sensores.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_sensores
// Directed bench for sequenciador_sensores (N=4, WATCHDOG=20, INTERVALO=10)
// with a behavioral model of the ultrasonic interface. A response plan
// queue drives the model; expected per-sensor results are queued when the
// model answers (or is told to stay silent) and checked at each PROXIMO.
// ---------------------------------------------------------------------------
module tb_sequenciador_sensores;
  localparam int N = 4;
  localparam int W = 20;
  localparam int I = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ligar = 1'b0;
  logic [1:0]    sel_sensor;
  logic [47:0]   medidas;
  logic [3:0]    falha;
  logic          ciclo_pronto;
  logic [3:0]    db_estado;

  sequenciador_sensores_if bus ();

  sequenciador_sensores #(
    .N_SENSORES (N),
    .WATCHDOG   (W),
    .INTERVALO  (I)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ligar        (ligar),
    .bus          (bus.master),
    .sel_sensor   (sel_sensor),
    .medidas      (medidas),
    .falha        (falha),
    .ciclo_pronto (ciclo_pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // atraso < 0 means the interface model never answers
  typedef struct { int sensor; int atraso; logic [11:0] valor; } plano_t;
  typedef struct { int sensor; logic timeout; logic [11:0] valor; } esperado_t;

  plano_t    plano[$];
  esperado_t fila[$];
  logic [47:0] medidas_mod = 48'h0;
  logic [3:0]  falha_mod   = 4'h0;

  int vectors     = 0;
  int miscompares = 0;
  int ult_medir_cyc = 0;
  int n_reset_if    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic planejar(input int s, input int d, input logic [11:0] v);
    plano_t p;
    p.sensor = s; p.atraso = d; p.valor = v;
    plano.push_back(p);
  endtask

  task automatic esperar_ciclo(input string tag);
    int n = 0;
    do begin @(negedge clock); n++; end while (ciclo_pronto !== 1'b1 && n < 400);
    check(tag, ciclo_pronto, 1'b1);
  endtask

  task automatic esperar_estado(input string tag, input logic [3:0] e);
    int n = 0;
    do begin @(negedge clock); n++; end while (db_estado !== e && n < 400);
    check(tag, db_estado, e);
  endtask

  task automatic esperar_aguarda(input string tag, input logic [1:0] s);
    int n = 0;
    do begin @(negedge clock); n++; end
    while (!(db_estado === 4'd3 && sel_sensor === s) && n < 400);
    check(tag, {sel_sensor, db_estado}, {s, 4'd3});
  endtask

  task automatic contar_ate_medir(output int n, output int n_espera);
    n = 0; n_espera = 0;
    do begin
      @(negedge clock); n++;
      if (db_estado === 4'd7) n_espera++;
    end while (bus.medir_if !== 1'b1 && n < 50);
  endtask

  // Behavioral interface model: answers each request per the plan queue
  initial begin
    plano_t    p;
    esperado_t e;
    bus.pronto_if = 1'b0;
    bus.medida_if = 12'h000;
    forever begin
      @(negedge clock);
      if (bus.medir_if === 1'b1) begin
        ult_medir_cyc = cyc;
        if (plano.size() == 0) begin
          check("medir_inesperado", 1'b1, 1'b0);
        end else begin
          p = plano.pop_front();
          check("sel_no_disparo", sel_sensor, p.sensor);
          if (p.atraso < 0) begin
            e.sensor = p.sensor; e.timeout = 1'b1; e.valor = 12'h000;
            fila.push_back(e);
          end else begin
            repeat (p.atraso) @(negedge clock);
            bus.pronto_if = 1'b1;
            bus.medida_if = p.valor;
            e.sensor = p.sensor; e.timeout = 1'b0; e.valor = p.valor;
            fila.push_back(e);
            @(negedge clock);
            bus.pronto_if = 1'b0;
            bus.medida_if = 12'h000;
            check("pronto_para_armazena", db_estado, 4'd4);
          end
        end
      end
    end
  end

  // Scoreboard: pops one expected result per PROXIMO; checks reset_if timing
  initial begin
    esperado_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        if (bus.reset_if === 1'b1) begin
          n_reset_if++;
          check("latencia_reset_if", cyc - ult_medir_cyc, W + 1);
        end
        if (ciclo_pronto === 1'b1) check("ciclo_no_proximo", db_estado, 4'd6);
        if (db_estado === 4'd6) begin
          if (fila.size() == 0) begin
            check("fila_vazia", 1'b1, 1'b0);
          end else begin
            e = fila.pop_front();
            if (e.timeout) begin
              falha_mod[e.sensor] = 1'b1;
            end else begin
              falha_mod[e.sensor] = 1'b0;
              medidas_mod[12*e.sensor +: 12] = e.valor;
            end
            check("sel_no_proximo", sel_sensor, e.sensor);
            check("medidas", medidas, medidas_mod);
            check("falha", falha, falha_mod);
            check("ciclo_pronto", ciclo_pronto, (e.sensor == N - 1));
          end
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int n, n_esp, n_medir;

    // Reset values
    repeat (2) @(negedge clock);
    #1;
    check("rst_estado", db_estado, 4'd0);
    check("rst_medir", bus.medir_if, 1'b0);
    check("rst_reset_if", bus.reset_if, 1'b0);
    check("rst_sel", sel_sensor, 2'd0);
    check("rst_medidas", medidas, 48'h0);
    check("rst_falha", falha, 4'h0);
    check("rst_ciclo", ciclo_pronto, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("inicial_parado", db_estado, 4'd0);

    // Rounds 1..4 planned up front
    planejar(0, 5, 12'h010); planejar(1, 5, 12'h020);
    planejar(2, 5, 12'h030); planejar(3, 5, 12'h040);
    planejar(0, 5, 12'h011); planejar(1, 5, 12'h021);
    planejar(2, -1, 12'h000); planejar(3, 5, 12'h041);
    planejar(0, 3, 12'h012); planejar(1, 7, 12'h022);
    planejar(2, 5, 12'h055); planejar(3, W, 12'h043);
    planejar(0, 5, 12'h013); planejar(1, 10, 12'h023);
    planejar(2, 5, 12'h033); planejar(3, 5, 12'h044);

    // 1. Nominal round, then the idle interval
    ligar = 1'b1;
    esperar_ciclo("r1_ciclo");
    check("r1_medidas", medidas, 48'h040_030_020_010);
    check("r1_falha", falha, 4'b0000);
    contar_ate_medir(n, n_esp);
    check("r1_ciclos_espera", n_esp, I);
    check("r1_espera_ate_medir", n, I + 2);

    // 2. Timeout on sensor 2
    esperar_ciclo("r2_ciclo");
    check("r2_medidas", medidas, 48'h041_030_021_011);
    check("r2_falha", falha, 4'b0100);
    check("r2_n_reset_if", n_reset_if, 1);

    // 3./4. Recovery of sensor 2, and pronto exactly at the watchdog limit
    esperar_ciclo("r3_ciclo");
    check("r3_medidas", medidas, 48'h043_055_022_012);
    check("r3_falha", falha, 4'b0000);
    check("r3_n_reset_if", n_reset_if, 1);

    // 5. ligar dropped during sensor 1 AGUARDA: round completes, then stop
    esperar_aguarda("r4_aguarda_s1", 2'd1);
    ligar = 1'b0;
    esperar_ciclo("r4_ciclo");
    check("r4_medidas", medidas, 48'h044_033_023_013);
    @(negedge clock);
    check("r4_volta_inicial", db_estado, 4'd0);
    n_medir = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.medir_if === 1'b1) n_medir++;
    end
    check("r4_medir_parado", n_medir, 0);
    check("r4_plano_consumido", plano.size(), 0);

    // 6. Asynchronous reset in the middle of AGUARDA
    planejar(0, -1, 12'h000);
    ligar = 1'b1;
    esperar_aguarda("r5_aguarda_s0", 2'd0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_estado", db_estado, 4'd0);
    check("arst_medir", bus.medir_if, 1'b0);
    check("arst_reset_if", bus.reset_if, 1'b0);
    check("arst_sel", sel_sensor, 2'd0);
    check("arst_medidas", medidas, 48'h0);
    check("arst_falha", falha, 4'h0);
    check("arst_ciclo", ciclo_pronto, 1'b0);
    fila.delete();
    plano.delete();
    medidas_mod = 48'h0;
    falha_mod   = 4'h0;
    @(negedge clock);
    planejar(0, 5, 12'h0A0); planejar(1, 5, 12'h0B0);
    planejar(2, 5, 12'h0C0); planejar(3, 5, 12'h0D0);
    #2 reset = 1'b1;
    contar_ate_medir(n, n_esp);
    check("latencia_ligar", n, 2);
    check("reinicio_sensor0", sel_sensor, 2'd0);
    esperar_ciclo("r6_ciclo");
    check("r6_medidas", medidas, 48'h0D0_0C0_0B0_0A0);
    check("r6_falha", falha, 4'b0000);
    ligar = 1'b0;
    esperar_estado("r6_inicial", 4'd0);
    check("fila_final", fila.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sequenciador_sensores.md
Name: sequenciador_sensores

Overview:
- Controller that time-shares one ultrasonic interface block (medir/pronto/medida handshake) between N_SENSORES HC-SR04 sensors.
- Selects each sensor in turn through external echo/trigger muxes. Issues a one-cycle measurement request per sensor.
- Supervises each request with a watchdog. On timeout, resets the interface and flags the sensor.
- Stores the last good distance per sensor, pulses an end-of-round flag, then waits a fixed interval before the next round.

Parameters:
- N_SENSORES, 4, number of sensors served; range 2..4.
- WATCHDOG, 1500000, clock cycles to wait for pronto_if after the request (30 ms at 50 MHz).
- INTERVALO, 3000000, idle cycles between the end of one round and the start of the next (60 ms at 50 MHz).

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- ligar  in  1  level; 1 = run rounds continuously.
- pronto_if  in  1  one-cycle done pulse from the interface.
- medida_if  in  12  distance from the interface; valid while pronto_if=1.
- medir_if  out  1  one-cycle measurement request to the interface.
- reset_if  out  1  one-cycle active-high reset to the interface.
- sel_sensor  out  2  index of the active sensor; drives the echo/trigger muxes.
- medidas  out  12*N_SENSORES  last good distance per sensor; sensor k occupies bits [12k+11:12k].
- falha  out  N_SENSORES  bit k = 1 if the last attempt on sensor k timed out.
- ciclo_pronto  out  1  one-cycle pulse when a round completes.
- db_estado  out  4  current state code.

Behaviour:
- Reset (reset=0, asynchronous): state=INICIAL, sel_sensor=0, medidas=0, falha=0, all counters=0, medir_if=reset_if=ciclo_pronto=0.
- db_estado codes: INICIAL=0, PREPARA=1, DISPARA=2, AGUARDA=3, ARMAZENA=4, FALHA=5, PROXIMO=6, ESPERA=7.
- INICIAL:
  - ligar=1 → PREPARA with sel_sensor=0.
  - Otherwise hold.
- PREPARA: exactly one cycle so the mux settles; clear the watchdog counter → DISPARA.
- DISPARA: medir_if=1 for exactly this cycle → AGUARDA.
- AGUARDA: watchdog counter increments every cycle.
  - pronto_if=1 → ARMAZENA, with medida_if captured into an internal register on that same edge.
  - Counter reaches WATCHDOG-1 with no pronto → FALHA.
  - pronto_if and the timeout in the same cycle: pronto wins.
- ARMAZENA (one cycle): write the captured value into the medidas slot for sel_sensor; clear falha[sel_sensor] → PROXIMO.
- FALHA (one cycle): reset_if=1; set falha[sel_sensor]; the medidas slot keeps its old value → PROXIMO.
- PROXIMO (one cycle):
  - If sel_sensor < N_SENSORES-1: sel_sensor+1 → PREPARA.
  - Otherwise ciclo_pronto=1 and sel_sensor=0.
    - ligar=1 → ESPERA with the interval counter cleared.
    - ligar=0 → INICIAL.
- ESPERA:
  - Interval counter increments; reaching INTERVALO-1 → PREPARA.
  - ligar=0 during ESPERA → INICIAL immediately.
- Clearing ligar mid-round does not abort the round. The round completes; ligar is sampled only in PROXIMO (last sensor) and in ESPERA.
- Latency:
  - ligar rising in INICIAL: medir_if fires 2 cycles later.
  - pronto_if: medidas updates 2 edges later (capture, then ARMAZENA write).
  - Timeout: reset_if fires WATCHDOG+1 cycles after medir_if.
- pronto_if pulses outside AGUARDA are ignored.
- sel_sensor is stable from PREPARA through PROXIMO of each sensor.
- Counter widths are sized by $clog2 of the parameter. Counters never wrap because they are cleared on state entry.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Test Plan:
Bench parameters: N_SENSORES=4, WATCHDOG=20, INTERVALO=10, with a behavioral model of the interface.
1. Nominal round: the model answers pronto after 5 cycles with medidas 0x010, 0x020, 0x030, 0x040 → medidas=0x040_030_020_010, falha=0000, one ciclo_pronto pulse, then 10 ESPERA cycles, then medir_if again.
2. Timeout on sensor 2 (the model never answers) → reset_if pulses 21 cycles after medir_if; falha=0100; slot 2 keeps its previous value; sensors 3 and 0 are measured normally.
3. Recovery: the round after scenario 2 succeeds for sensor 2 with 0x055 → falha[2] clears; slot 2=0x055.
4. pronto arrives exactly at the watchdog limit (cycle 19 of AGUARDA) → ARMAZENA taken, no reset_if, falha bit stays 0.
5. ligar dropped while sensor 1 is in AGUARDA → sensors 1..3 still measured, ciclo_pronto pulses, state returns to INICIAL (db_estado=0), medir_if stays low afterwards.
6. reset asserted asynchronously mid-AGUARDA → all outputs return to reset values immediately, without a clock edge; after release with ligar=1, the round restarts at sensor 0.
